// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// mc_ctrl_fsm : multicycle main-control FSM for the RV32I+F core
// Rev 1.0
// ============================================================================
module mc_ctrl_fsm #(
    parameter int MEM_HS  = 0,
    parameter int MEM_LAT = 2,
    parameter int TMO_CYC = 0,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [6:0]       op,
    input  logic             mem_valid,
    input  logic             uart_done,
    input  logic             flpt_done,
    input  logic             halt_req,
    output logic             mem_req,
    output logic             pcwrite,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             fregwrite,
    output logic             pcbufwrite,
    output logic             iord,
    output logic             branch,
    output logic             rors,
    output logic             uart_go,
    output logic             iorf,
    output logic             indecode,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [2:0]       regsrc,
    output logic [2:0]       aluop,
    output logic             illegal,
    output logic             timeout,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] c_op_lw    = 7'b0000011;
    localparam logic [6:0] c_op_flw   = 7'b0000111;
    localparam logic [6:0] c_op_sw    = 7'b0100011;
    localparam logic [6:0] c_op_fsw   = 7'b0100111;
    localparam logic [6:0] c_op_r     = 7'b0110011;
    localparam logic [6:0] c_op_i     = 7'b0010011;
    localparam logic [6:0] c_op_b     = 7'b1100011;
    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_auipc = 7'b0010111;
    localparam logic [6:0] c_op_jal   = 7'b1101111;
    localparam logic [6:0] c_op_jalr  = 7'b1100111;
    localparam logic [6:0] c_op_recv  = 7'b0000001;
    localparam logic [6:0] c_op_send  = 7'b0000010;
    localparam logic [6:0] c_op_fp    = 7'b1010011;

    localparam logic [15:0] c_lat_last = 16'(MEM_LAT - 1);
    localparam logic [15:0] c_tmo_last = 16'(TMO_CYC - 1);

    typedef enum logic [4:0] {
        S_IDLE, S_FETCH, S_IWAIT, S_DECODE, S_MEMADR, S_DREQ, S_DWAIT,
        S_MEMWB, S_FMEMWB, S_STORE, S_EXEC, S_ALUWB, S_IMMEX, S_IMMWB,
        S_BRANCH, S_LUI, S_AUIPC, S_JAL, S_JALR, S_SEND_GO, S_SEND_WAIT,
        S_RECV_GO, S_RECV_WAIT, S_RECV_WB, S_FEXEC, S_HALT, S_TRAP
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_wcnt;
    logic             r_illegal;
    logic             r_timeout;
    logic [CNT_W-1:0] r_instret;
    logic             w_data_ok;
    logic             w_tmo_hit;
    logic             w_retire;
    logic             w_set_tmo;

    assign w_data_ok = (MEM_HS != 0) ? mem_valid : (r_wcnt == c_lat_last);
    assign w_tmo_hit = (TMO_CYC > 0) && (r_wcnt == c_tmo_last);

    assign illegal = r_illegal;
    assign timeout = r_timeout;
    assign instret = r_instret;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_wcnt    <= '0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            // Any state change restarts the wait count, so every wait state begins at 0.
            if (w_next != r_state) begin
                r_wcnt <= '0;
            end else if (r_wcnt != '1) begin
                r_wcnt <= r_wcnt + 16'd1;
            end
            if (w_next == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (w_set_tmo) begin
                r_timeout <= 1'b1;
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_retire   = 1'b0;
        w_set_tmo  = 1'b0;
        mem_req    = 1'b0;
        pcwrite    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        fregwrite  = 1'b0;
        pcbufwrite = 1'b0;
        iord       = 1'b0;
        branch     = 1'b0;
        rors       = 1'b0;
        uart_go    = 1'b0;
        iorf       = 1'b0;
        indecode   = 1'b0;
        halted     = 1'b0;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        regsrc     = 3'b000;
        aluop      = 3'b000;

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                mem_req    = 1'b1;
                pcwrite    = 1'b1;
                pcbufwrite = 1'b1;
                alusrcb    = 2'b01;
                w_next     = S_IWAIT;
            end
            S_IWAIT: begin
                if (w_data_ok) begin
                    irwrite = 1'b1;
                    w_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                indecode = 1'b1;
                case (op)
                    c_op_lw, c_op_flw, c_op_sw, c_op_fsw: w_next = S_MEMADR;
                    c_op_r:     w_next = S_EXEC;
                    c_op_i:     w_next = S_IMMEX;
                    c_op_b:     w_next = S_BRANCH;
                    c_op_lui:   w_next = S_LUI;
                    c_op_auipc: w_next = S_AUIPC;
                    c_op_jal:   w_next = S_JAL;
                    c_op_jalr:  w_next = S_JALR;
                    c_op_recv:  w_next = S_RECV_GO;
                    c_op_send:  w_next = S_SEND_GO;
                    c_op_fp:    w_next = S_FEXEC;
                    default:    w_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b10;
                w_next  = (op == c_op_sw || op == c_op_fsw) ? S_STORE : S_DREQ;
            end
            S_DREQ: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                w_next  = S_DWAIT;
            end
            S_DWAIT: begin
                iord = 1'b1;
                if (w_data_ok) begin
                    w_next = (op == c_op_flw) ? S_FMEMWB : S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                regsrc   = 3'b001;
                w_retire = 1'b1;
            end
            S_FMEMWB: begin
                fregwrite = 1'b1;
                w_retire  = 1'b1;
            end
            S_STORE: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                mem_req  = 1'b1;
                iorf     = (op == c_op_fsw);
                w_retire = w_data_ok;
            end
            S_EXEC: begin
                alusrca = 2'b10;
                aluop   = 3'b100;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                w_retire = 1'b1;
            end
            S_IMMEX: begin
                alusrca = 2'b10;
                alusrcb = 2'b10;
                aluop   = 3'b101;
                w_next  = S_IMMWB;
            end
            S_IMMWB: begin
                regwrite = 1'b1;
                w_retire = 1'b1;
            end
            S_BRANCH: begin
                alusrca  = 2'b10;
                pcsrc    = 2'b01;
                branch   = 1'b1;
                aluop    = 3'b111;
                w_retire = 1'b1;
            end
            S_LUI: begin
                regwrite = 1'b1;
                regsrc   = 3'b010;
                w_retire = 1'b1;
            end
            S_AUIPC: begin
                regwrite = 1'b1;
                w_retire = 1'b1;
            end
            S_JAL: begin
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                regsrc   = 3'b011;
                pcsrc    = 2'b01;
                w_retire = 1'b1;
            end
            S_JALR: begin
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                regsrc   = 3'b011;
                alusrca  = 2'b10;
                alusrcb  = 2'b10;
                pcsrc    = 2'b10;
                w_retire = 1'b1;
            end
            S_SEND_GO: begin
                rors    = 1'b1;
                uart_go = 1'b1;
                w_next  = S_SEND_WAIT;
            end
            S_SEND_WAIT: begin
                // Completion on the expiry cycle takes the normal path.
                if (uart_done) begin
                    w_retire = 1'b1;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            S_RECV_GO: begin
                uart_go = 1'b1;
                w_next  = S_RECV_WAIT;
            end
            S_RECV_WAIT: begin
                if (uart_done) begin
                    w_next = S_RECV_WB;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            S_RECV_WB: begin
                regwrite = 1'b1;
                regsrc   = 3'b100;
                w_retire = 1'b1;
            end
            S_FEXEC: begin
                if (flpt_done) begin
                    w_retire = 1'b1;
                end else if (w_tmo_hit) begin
                    w_set_tmo = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    w_next = S_FETCH;
                end
            end
            S_TRAP: halted = 1'b1;
            default: w_next = S_IDLE;
        endcase

        if (w_retire) begin
            w_next = halt_req ? S_HALT : S_FETCH;
        end

        // The cycle in which reset is sampled must not commit any write or request.
        if (!rstn) begin
            mem_req    = 1'b0;
            pcwrite    = 1'b0;
            memwrite   = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            fregwrite  = 1'b0;
            pcbufwrite = 1'b0;
            uart_go    = 1'b0;
        end
    end

endmodule
`default_nettype wire
